// File: rtl/hh_step_sequencer.sv
// hh_step_sequencer
// Paces Hodgkin-Huxley Euler steps with a prescaler. In each step it issues the
// four gate/voltage update operations (n, m, h, V) to a shared datapath, then
// evaluates the updated membrane voltage for an upward threshold crossing,
// subject to a refractory window measured in steps.
module hh_step_sequencer #(
    parameter logic signed [7:0] V_TH    = 8'sd20,
    parameter int unsigned       REFRACT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [7:0]        step_period,
    input  logic [7:0]        stim_in,
    output logic              mac_req,
    output logic [1:0]        mac_op,
    input  logic              mac_ack,
    input  logic signed [7:0] v_in,
    output logic [7:0]        i_ext_q,
    output logic              spike,
    output logic              step_done,
    output logic [7:0]        spike_count,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam logic [3:0] REFRACT_LD = 4'(REFRACT);

    typedef enum logic [2:0] {
        IDLE,
        OP_N,
        OP_M,
        OP_H,
        OP_V,
        CHECK
    } state_t;

    state_t             r_state;
    logic [7:0]         r_presc;
    logic               r_mac_req;
    logic [1:0]         r_mac_op;
    logic [7:0]         r_i_ext_q;
    logic               r_spike;
    logic               r_step_done;
    logic [7:0]         r_spike_count;
    logic               r_overrun;
    logic [3:0]         r_refr_cnt;
    logic signed [7:0]  r_v_prev;

    logic [7:0]         w_presc_max;
    logic               w_tick;
    logic               w_crossing;

    // A period of 0 behaves like 1, so the prescaler then ticks every enabled cycle.
    assign w_presc_max = (step_period == 8'd0) ? 8'd0 : (step_period - 8'd1);
    assign w_tick      = ena && (r_presc == w_presc_max);

    // A spike needs an upward crossing (previous step below, this step at/above)
    // and an expired refractory window.
    assign w_crossing  = (v_in >= V_TH) && (r_v_prev < V_TH) && (r_refr_cnt == 4'd0);

    // Step prescaler: counts enabled cycles, freezes while ena is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= 8'd0;
        end else if (ena) begin
            if (w_tick) begin
                r_presc <= 8'd0;
            end else begin
                r_presc <= r_presc + 8'd1;
            end
        end
    end

    // Sticky overrun: a tick that arrives while a step is still busy is dropped
    // and flagged; a simultaneous clear loses to the new event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_tick && (r_state != IDLE)) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    // Step sequencer: latches the stimulus, walks n->m->h->V on the datapath
    // handshake, then spends one cycle deciding whether this step spiked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_mac_req     <= 1'b0;
            r_mac_op      <= 2'd0;
            r_i_ext_q     <= 8'd0;
            r_spike       <= 1'b0;
            r_step_done   <= 1'b0;
            r_spike_count <= 8'd0;
            r_refr_cnt    <= 4'd0;
            r_v_prev      <= 8'sh80;
        end else begin
            r_spike     <= 1'b0;
            r_step_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_tick) begin
                        r_state   <= OP_N;
                        r_i_ext_q <= stim_in;
                        r_mac_req <= 1'b1;
                        r_mac_op  <= 2'd0;
                    end
                end
                OP_N: begin
                    if (mac_ack) begin
                        r_state  <= OP_M;
                        r_mac_op <= 2'd1;
                    end
                end
                OP_M: begin
                    if (mac_ack) begin
                        r_state  <= OP_H;
                        r_mac_op <= 2'd2;
                    end
                end
                OP_H: begin
                    if (mac_ack) begin
                        r_state  <= OP_V;
                        r_mac_op <= 2'd3;
                    end
                end
                OP_V: begin
                    if (mac_ack) begin
                        r_state   <= CHECK;
                        r_mac_req <= 1'b0;
                    end
                end
                CHECK: begin
                    r_state     <= IDLE;
                    r_spike     <= w_crossing;
                    r_step_done <= 1'b1;
                    r_v_prev    <= v_in;
                    if (w_crossing) begin
                        r_spike_count <= r_spike_count + 8'd1;
                        r_refr_cnt    <= REFRACT_LD;
                    end else if (r_refr_cnt != 4'd0) begin
                        r_refr_cnt <= r_refr_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mac_req <= 1'b0;
                end
            endcase
        end
    end

    assign mac_req     = r_mac_req;
    assign mac_op      = r_mac_op;
    assign i_ext_q     = r_i_ext_q;
    assign spike       = r_spike;
    assign step_done   = r_step_done;
    assign spike_count = r_spike_count;
    assign overrun     = r_overrun;

endmodule
